key_debounce_n: RTL
===================

KEY_DEBOUNCE_N -- requirements
Module: key_debounce_n

Interface
REQ-001 Parameter N, default 4: number of independent key channels, range 1..32.
REQ-002 Parameter DEB_CYC, default 250000: debounce interval in clk cycles (10 ms at 25 MHz), minimum 2.
REQ-003 Parameter RPT_DLY, default 12500000: held time before the first auto-repeat pulse (0.5 s), minimum 1.
REQ-004 Parameter RPT_PER, default 2500000: auto-repeat period (0.1 s), minimum 1.
REQ-005 clk  input  1  system clock, 25 MHz nominal.
REQ-006 rstn  input  1  reset, asynchronous, active-low.
REQ-007 en  input  1  global enable; low forces every channel idle.
REQ-008 key_in  input  N  raw asynchronous key levels, 1 = pressed.
REQ-009 rpt_en  input  N  per-channel auto-repeat enable.
REQ-010 key_lvl  output  N  debounced key level.
REQ-011 press_p  output  N  one-cycle pulse on debounced press.
REQ-012 release_p  output  N  one-cycle pulse on debounced release.
REQ-013 rpt_p  output  N  one-cycle auto-repeat pulse.
REQ-014 key_any  output  1  OR of all key_lvl bits.

Function
REQ-015 Each key_in bit SHALL pass through a 2-flop synchronizer; the FSM SHALL see only the synchronized value s.
REQ-016 Each channel SHALL run an independent FSM with states IDLE, DEB_DN, HELD, REPEAT and DEB_UP, plus a counter sized to $clog2 of max(DEB_CYC, RPT_DLY, RPT_PER).
REQ-017 IDLE: s=1 SHALL go to DEB_DN with cnt=0.
REQ-018 DEB_DN: s=0 SHALL return to IDLE with no pulse; cnt==DEB_CYC-1 SHALL go to HELD, set key_lvl=1, pulse press_p and clear cnt; otherwise cnt SHALL increment.
REQ-019 HELD: s=0 SHALL go to DEB_UP with cnt=0.
REQ-020 HELD, else if rpt_en=1 and cnt==RPT_DLY-1: SHALL go to REPEAT, pulse rpt_p and clear cnt.
REQ-021 HELD, else if rpt_en=1: cnt SHALL increment.
REQ-022 HELD with rpt_en=0: cnt SHALL hold at 0.
REQ-023 REPEAT: s=0 SHALL go to DEB_UP with cnt=0.
REQ-024 REPEAT, else if rpt_en=0: SHALL go to HELD with cnt=0.
REQ-025 REPEAT, else if cnt==RPT_PER-1: SHALL pulse rpt_p and clear cnt; otherwise cnt SHALL increment.
REQ-026 DEB_UP: s=1 SHALL return to HELD with cnt=0, key_lvl staying 1 and no pulse; cnt==DEB_CYC-1 SHALL go to IDLE, set key_lvl=0 and pulse release_p; otherwise cnt SHALL increment.
REQ-027 Press latency: with key_in stable high, press_p SHALL be high for exactly the one cycle following the (DEB_CYC+2)th rising edge after the edge that first samples key_in=1.
REQ-028 Release latency SHALL be symmetric to press latency.
REQ-029 Priority: s=0 SHALL override a terminal repeat count in the same cycle (no rpt_p).
REQ-030 press_p, rpt_p and release_p of a channel SHALL be mutually exclusive in any cycle.
REQ-031 All pulse and level outputs SHALL be registered; key_any MAY be combinational from the registered key_lvl.
REQ-032 en=0 SHALL synchronously return every FSM to IDLE with cnt=0 and all outputs 0, without release_p.
REQ-033 When en returns high, a key still held SHALL be re-debounced and produce a fresh press_p.

Reset
REQ-034 rstn low SHALL asynchronously clear the synchronizers, FSMs (to IDLE), counters, key_lvl, press_p, release_p, rpt_p and key_any to 0.
REQ-035 Reset asserted mid-operation SHALL emit no pulse; a key held across reset release SHALL follow REQ-027.

Structure
REQ-036 State encodings SHALL live in the shared package key_pkg.
REQ-037 key_pkg SHALL provide the counter-width helper.
REQ-038 One channel (synchronizer, FSM, counter) SHALL be sub-module key_chan, instantiated N times via generate.
REQ-039 The top level SHALL contain only the generate loop and the key_any reduction.

Verification (N=4, DEB_CYC=4, RPT_DLY=10, RPT_PER=3)
REQ-040 key_in[0] high 20 cycles then low -> press_p[0] once at edge 6, key_lvl[0] high, release_p[0] once 6 edges after the fall, no rpt_p.
REQ-041 key_in[1] high 3 cycles -> no pulses, key_lvl[1] stays 0.
REQ-042 key_in[2] held 40 cycles, rpt_en[2]=1 -> rpt_p[2] at press+10, then every 3 cycles; rpt_en dropped -> pulses stop, key_lvl stays 1.
REQ-043 While held, key_in[3] low 2 cycles then high -> no release_p or press_p; key_lvl[3] constant 1.
REQ-044 All 4 keys pressed together -> 4 simultaneous press_p and key_any=1; en=0 mid-hold -> all outputs 0 next cycle; en=1 -> new press_p after 4 cycles.
REQ-045 rstn pulsed during REPEAT -> all outputs 0 immediately; key still held -> press_p at edge 6 after reset release.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the key debounce block: channel state encoding and
// the counter width helper used by every channel.
package key_pkg;

    typedef enum logic [2:0] {
        KEY_IDLE   = 3'd0,
        KEY_DEB_DN = 3'd1,
        KEY_HELD   = 3'd2,
        KEY_REPEAT = 3'd3,
        KEY_DEB_UP = 3'd4
    } key_state_e;

    // Width of a counter that must reach max(a, b, c) - 1; never less than 1 bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (m <= 2) return 1;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/key_chan.sv
// One key channel: 2-flop synchronizer, debounce / auto-repeat FSM and its
// shared counter. All outputs come straight from flops.
module key_chan
    import key_pkg::*;
#(
    parameter int DEB_CYC = 250000,
    parameter int RPT_DLY = 12500000,
    parameter int RPT_PER = 2500000
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  logic key_in,
    input  logic rpt_en,
    output logic key_lvl,
    output logic press_p,
    output logic release_p,
    output logic rpt_p
);

    localparam int CW = cnt_width(DEB_CYC, RPT_DLY, RPT_PER);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYC - 1);
    localparam logic [CW-1:0] DLY_LAST = CW'(RPT_DLY - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(RPT_PER - 1);

    logic [1:0]    sync_q, sync_d;
    key_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          rpt_q, rpt_d;
    logic          s;

    assign s = sync_q[1];

    // Next-state, counter and pulse decode for one channel.
    always_comb begin
        // NOTE: every _d gets a default before the case so no path can leave
        // it unassigned, which would otherwise infer a latch.
        sync_d    = {sync_q[0], key_in};
        state_d   = state_q;
        cnt_d     = cnt_q;
        lvl_d     = lvl_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        rpt_d     = 1'b0;

        if (!en) begin
            // Disable drops straight to idle without announcing a release.
            state_d = KEY_IDLE;
            cnt_d   = '0;
            lvl_d   = 1'b0;
        end else begin
            unique case (state_q)
                KEY_IDLE: begin
                    lvl_d = 1'b0;
                    if (s) begin
                        state_d = KEY_DEB_DN;
                        cnt_d   = '0;
                    end
                end
                KEY_DEB_DN: begin
                    if (!s) begin
                        state_d = KEY_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d = KEY_HELD;
                        cnt_d   = '0;
                        lvl_d   = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                KEY_HELD: begin
                    if (!s) begin
                        state_d = KEY_DEB_UP;
                        cnt_d   = '0;
                    end else if (!rpt_en) begin
                        cnt_d = '0;
                    end else if (cnt_q == DLY_LAST) begin
                        state_d = KEY_REPEAT;
                        cnt_d   = '0;
                        rpt_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                KEY_REPEAT: begin
                    // A falling key wins over a terminal repeat count.
                    if (!s) begin
                        state_d = KEY_DEB_UP;
                        cnt_d   = '0;
                    end else if (!rpt_en) begin
                        state_d = KEY_HELD;
                        cnt_d   = '0;
                    end else if (cnt_q == PER_LAST) begin
                        cnt_d = '0;
                        rpt_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                KEY_DEB_UP: begin
                    if (s) begin
                        // Bounce while releasing: key is still down, stay pressed.
                        state_d = KEY_HELD;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d   = KEY_IDLE;
                        cnt_d     = '0;
                        lvl_d     = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = KEY_IDLE;
                    cnt_d   = '0;
                    lvl_d   = 1'b0;
                end
            endcase
        end
    end

    // Register synchronizer, FSM, counter and all outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q    <= '0;
            state_q   <= KEY_IDLE;
            cnt_q     <= '0;
            lvl_q     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            rpt_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values,
            // which is what makes the two sync stages a real 2-cycle delay.
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lvl_q     <= lvl_d;
            press_q   <= press_d;
            release_q <= release_d;
            rpt_q     <= rpt_d;
        end
    end

    assign key_lvl   = lvl_q;
    assign press_p   = press_q;
    assign release_p = release_q;
    assign rpt_p     = rpt_q;

endmodule

// File: rtl/key_debounce_n.sv
// N independent debounced key channels with optional auto-repeat.
module key_debounce_n #(
    parameter int N       = 4,
    parameter int DEB_CYC = 250000,
    parameter int RPT_DLY = 12500000,
    parameter int RPT_PER = 2500000
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic [N-1:0] key_in,
    input  logic [N-1:0] rpt_en,
    output logic [N-1:0] key_lvl,
    output logic [N-1:0] press_p,
    output logic [N-1:0] release_p,
    output logic [N-1:0] rpt_p,
    output logic         key_any
);

    // One channel per key.
    for (genvar i = 0; i < N; i++) begin : g_chan
        key_chan #(
            .DEB_CYC(DEB_CYC),
            .RPT_DLY(RPT_DLY),
            .RPT_PER(RPT_PER)
        ) u_chan (
            .clk      (clk),
            .rstn     (rstn),
            .en       (en),
            .key_in   (key_in[i]),
            .rpt_en   (rpt_en[i]),
            .key_lvl  (key_lvl[i]),
            .press_p  (press_p[i]),
            .release_p(release_p[i]),
            .rpt_p    (rpt_p[i])
        );
    end

    assign key_any = |key_lvl;

endmodule
